pc_sequencer: RTL and testbench

Program-counter sequencer for the single-cycle processor: owns the PC register and a hardware return-address stack. It consumes the instruction decoder's branch-class outputs (`linkSrc`, `branchControl`) plus the effective address and condition flag, and selects the next PC for BR, BR.C, BR.SUB and RETURN. It sits between the decoder/EA unit and instruction memory, and adds a start/stall handshake and stack-fault handling.

---
 rtl/pc_sequencer.sv | 157 +++++++++++++++
 tb/tb_pc_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a hardware return-address stack.
//
// Owns the PC register. Selects the next PC for sequential flow and for the
// branch classes BR, BR.C, BR.SUB (push link) and RETURN (pop link).
// Has a start/stall handshake and handles stack overflow and underflow.
//
// Optional feature macro: PC_SEQ_FAULT_EN
//   defined   : overflow/underflow moves to FAULT and freezes the PC and the stack.
//   undefined : overflow overwrites the oldest entry; underflow falls through to pc+1.
//   Either way, overflow and underflow set the sticky stackErr flag.
//
// Ports:
//   clock         in  : rising-edge clock
//   reset         in  : synchronous, active-high reset
//   start         in  : one-cycle pulse that leaves IDLE
//   stall         in  : hold all state this cycle (RUN only)
//   linkSrc       in  : current instruction is branch-class
//   branchControl in  : 0 BR, 1 BR.C, 2 BR.SUB, 3 RETURN
//   condFlag      in  : BR.C is taken when high
//   effAddr       in  : branch target
//   pc            out : current instruction address (registered)
//   pcValid       out : high in RUN
//   linkAddr      out : top-of-stack entry, 0 when empty (combinational)
//   stackDepth    out : number of occupied stack entries
//   fault         out : high in FAULT
//   stackErr      out : sticky overflow/underflow flag
module pc_sequencer #(
  parameter int unsigned       ADDR_W       = 8,
  parameter int unsigned       DEPTH        = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stall,
  input  logic                       linkSrc,
  input  logic [1:0]                 branchControl,
  input  logic                       condFlag,
  input  logic [ADDR_W-1:0]          effAddr,
  output logic [ADDR_W-1:0]          pc,
  output logic                       pcValid,
  output logic [ADDR_W-1:0]          linkAddr,
  output logic [$clog2(DEPTH):0]     stackDepth,
  output logic                       fault,
  output logic                       stackErr
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StFault} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       pc_q, pc_d;
  logic [ADDR_W-1:0]       stack_q [DEPTH];
  logic [ADDR_W-1:0]       stack_d [DEPTH];
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;  // next slot to write; the top is wr_ptr_q-1
  logic [PtrW:0]           depth_q, depth_d;
  logic                    err_q, err_d;

  logic [ADDR_W-1:0]       pc_inc;
  logic [PtrW-1:0]         top_idx;
  logic                    full, empty;

  assign pc_inc  = pc_q + ADDR_W'(1);
  assign top_idx = wr_ptr_q - PtrW'(1);
  assign full    = (depth_q == (PtrW+1)'(DEPTH));
  assign empty   = (depth_q == '0);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    stack_d  = stack_q;
    wr_ptr_d = wr_ptr_q;
    depth_d  = depth_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        pc_d = RESET_VECTOR;
        if (start) state_d = StRun;
      end
      StRun: begin
        if (!stall) begin
          pc_d = pc_inc;
          if (linkSrc) begin
            unique case (branchControl)
              2'd0: pc_d = effAddr;
              2'd1: if (condFlag) pc_d = effAddr;
              2'd2: begin
                if (full) begin
                  err_d = 1'b1;
`ifdef PC_SEQ_FAULT_EN
                  state_d = StFault;
                  pc_d    = pc_q;
`else
                  // When the stack is full, the write slot holds the oldest entry,
                  // so this push overwrites it.
                  stack_d[wr_ptr_q] = pc_inc;
                  wr_ptr_d          = wr_ptr_q + PtrW'(1);
                  pc_d              = effAddr;
`endif
                end else begin
                  stack_d[wr_ptr_q] = pc_inc;
                  wr_ptr_d          = wr_ptr_q + PtrW'(1);
                  depth_d           = depth_q + (PtrW+1)'(1);
                  pc_d              = effAddr;
                end
              end
              2'd3: begin
                if (empty) begin
                  err_d = 1'b1;
`ifdef PC_SEQ_FAULT_EN
                  state_d = StFault;
                  pc_d    = pc_q;
`endif
                end else begin
                  pc_d     = stack_q[top_idx];
                  wr_ptr_d = top_idx;
                  depth_d  = depth_q - (PtrW+1)'(1);
                end
              end
              default: ;
            endcase
          end
        end
      end
      StFault: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= RESET_VECTOR;
      stack_q  <= '{default: '0};
      wr_ptr_q <= '0;
      depth_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      stack_q  <= stack_d;
      wr_ptr_q <= wr_ptr_d;
      depth_q  <= depth_d;
      err_q    <= err_d;
    end
  end

  assign pc         = pc_q;
  assign pcValid    = (state_q == StRun);
  assign fault      = (state_q == StFault);
  assign stackDepth = depth_q;
  assign stackErr   = err_q;
  assign linkAddr   = empty ? '0 : stack_q[top_idx];

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
module tb_pc_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       linkSrc = 1'b0;
  logic [1:0] branchControl = 2'd0;
  logic       condFlag = 1'b0;
  logic [7:0] effAddr = 8'h00;
  logic [7:0] pc;
  logic       pcValid;
  logic [7:0] linkAddr;
  logic [2:0] stackDepth;
  logic       fault;
  logic       stackErr;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(
    .ADDR_W      (8),
    .DEPTH       (4),
    .RESET_VECTOR(8'h00)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .linkSrc      (linkSrc),
    .branchControl(branchControl),
    .condFlag     (condFlag),
    .effAddr      (effAddr),
    .pc           (pc),
    .pcValid      (pcValid),
    .linkAddr     (linkAddr),
    .stackDepth   (stackDepth),
    .fault        (fault),
    .stackErr     (stackErr)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ls, input logic [1:0] bc, input logic [7:0] ea,
                       input logic cf);
    linkSrc       = ls;
    branchControl = bc;
    effAddr       = ea;
    condFlag      = cf;
  endtask

  // Reset, then pulse start; leaves pc=0 in RUN with non-branch inputs.
  task automatic reset_and_start();
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    stall = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    check_eq("rst_pc", pc, 8'h00);
    check_eq("rst_valid", pcValid, 1'b0);
    check_eq("rst_depth", stackDepth, 3'd0);
    check_eq("rst_link", linkAddr, 8'h00);
    check_eq("rst_fault", fault, 1'b0);
    check_eq("rst_err", stackErr, 1'b0);

    // IDLE ignores branches; start enters RUN without advancing the pc
    reset = 1'b0;
    drive(1'b1, 2'd0, 8'h55, 1'b0);
    step();
    check_eq("idle_pc", pc, 8'h00);
    check_eq("idle_valid", pcValid, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("start_pc", pc, 8'h00);
    check_eq("start_valid", pcValid, 1'b1);
    step(); check_eq("seq_pc1", pc, 8'h01);
    step(); check_eq("seq_pc2", pc, 8'h02);
    step(); check_eq("seq_pc3", pc, 8'h03);

    // Call and return
    drive(1'b1, 2'd0, 8'h10, 1'b0);
    step(); check_eq("br_pc", pc, 8'h10);
    drive(1'b1, 2'd2, 8'h40, 1'b0);
    step();
    check_eq("call_pc", pc, 8'h40);
    check_eq("call_link", linkAddr, 8'h11);
    check_eq("call_depth", stackDepth, 3'd1);
    drive(1'b1, 2'd3, 8'h99, 1'b0);
    step();
    check_eq("ret_pc", pc, 8'h11);
    check_eq("ret_depth", stackDepth, 3'd0);
    check_eq("ret_link", linkAddr, 8'h00);

    // Conditional branch and stall
    drive(1'b1, 2'd0, 8'h05, 1'b0);
    step(); check_eq("br5_pc", pc, 8'h05);
    drive(1'b1, 2'd1, 8'h20, 1'b0);
    step(); check_eq("brc_nt_pc", pc, 8'h06);
    drive(1'b1, 2'd1, 8'h20, 1'b1);
    step(); check_eq("brc_t_pc", pc, 8'h20);
    stall = 1'b1;
    drive(1'b1, 2'd0, 8'h80, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); check_eq("stall_pc", pc, 8'h20);
    end
    drive(1'b1, 2'd2, 8'h80, 1'b0);
    step(); check_eq("stall_call_depth", stackDepth, 3'd0);
    stall = 1'b0;

    // Wrap-around of pc+1 and of the pushed link
    drive(1'b1, 2'd0, 8'hFF, 1'b0);
    step(); check_eq("brff_pc", pc, 8'hFF);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step(); check_eq("wrap_pc", pc, 8'h00);
    drive(1'b1, 2'd0, 8'hFF, 1'b0);
    step();
    drive(1'b1, 2'd2, 8'h30, 1'b0);
    step();
    check_eq("wrap_call_pc", pc, 8'h30);
    check_eq("wrap_call_link", linkAddr, 8'h00);
    check_eq("wrap_call_depth", stackDepth, 3'd1);
    drive(1'b1, 2'd3, 8'h00, 1'b0);
    step(); check_eq("wrap_ret_pc", pc, 8'h00);
    check_eq("no_err_yet", stackErr, 1'b0);

    // Five calls into a four-entry stack; links are 01,41,51,61,71
    reset_and_start();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd2, 8'h40 + 8'(i * 16), 1'b0);
      step();
    end
    check_eq("ovf4_pc", pc, 8'h70);
    check_eq("ovf4_depth", stackDepth, 3'd4);
    check_eq("ovf4_err", stackErr, 1'b0);
    check_eq("ovf4_link", linkAddr, 8'h61);
    drive(1'b1, 2'd2, 8'h80, 1'b0);
    step();
`ifdef PC_SEQ_FAULT_EN
    check_eq("ovf_fault", fault, 1'b1);
    check_eq("ovf_err", stackErr, 1'b1);
    check_eq("ovf_pc", pc, 8'h70);
    check_eq("ovf_valid", pcValid, 1'b0);
    check_eq("ovf_depth", stackDepth, 3'd4);
    start = 1'b1;
    drive(1'b1, 2'd3, 8'h00, 1'b0);
    step();
    start = 1'b0;
    check_eq("fault_frozen_pc", pc, 8'h70);
    check_eq("fault_frozen_depth", stackDepth, 3'd4);
    check_eq("fault_held", fault, 1'b1);

    // Underflow faults too
    reset_and_start();
    check_eq("unf_clear_fault", fault, 1'b0);
    drive(1'b1, 2'd3, 8'h00, 1'b0);
    step();
    check_eq("unf_fault", fault, 1'b1);
    check_eq("unf_err", stackErr, 1'b1);
    check_eq("unf_pc", pc, 8'h00);
`else
    check_eq("ovf_pc", pc, 8'h80);
    check_eq("ovf_depth", stackDepth, 3'd4);
    check_eq("ovf_err", stackErr, 1'b1);
    check_eq("ovf_fault", fault, 1'b0);
    check_eq("ovf_link", linkAddr, 8'h71);
    drive(1'b1, 2'd3, 8'h00, 1'b0);
    step(); check_eq("pop1_pc", pc, 8'h71); check_eq("pop1_depth", stackDepth, 3'd3);
    step(); check_eq("pop2_pc", pc, 8'h61); check_eq("pop2_depth", stackDepth, 3'd2);
    step(); check_eq("pop3_pc", pc, 8'h51); check_eq("pop3_depth", stackDepth, 3'd1);
    step(); check_eq("pop4_pc", pc, 8'h41); check_eq("pop4_depth", stackDepth, 3'd0);
    // Underflow falls through to pc+1
    step();
    check_eq("unf_pc", pc, 8'h42);
    check_eq("unf_depth", stackDepth, 3'd0);
    check_eq("unf_err", stackErr, 1'b1);
    check_eq("unf_fault", fault, 1'b0);
    check_eq("unf_valid", pcValid, 1'b1);
`endif

    // Reset mid-RUN with two entries stacked
    reset_and_start();
    check_eq("rerun_err", stackErr, 1'b0);
    drive(1'b1, 2'd2, 8'h20, 1'b0);
    step();
    drive(1'b1, 2'd2, 8'h30, 1'b0);
    step();
    check_eq("pre_rst_depth", stackDepth, 3'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mid_rst_pc", pc, 8'h00);
    check_eq("mid_rst_depth", stackDepth, 3'd0);
    check_eq("mid_rst_valid", pcValid, 1'b0);
    check_eq("mid_rst_link", linkAddr, 8'h00);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();
    check_eq("post_rst_idle_pc", pc, 8'h00);
    check_eq("post_rst_idle_valid", pcValid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
